// File: rtl/vstu_commit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vstu_commit_ctrl_pkg: shared constants and queue entry type. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vstu_commit_ctrl_pkg;

  localparam int unsigned NrVInsn            = 8;
  localparam int unsigned VstuInsnQueueDepth = 4;
  localparam int unsigned VstuMaxOutstanding = 16;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  localparam int unsigned VInsnIdWidth = idx_width(NrVInsn);
  localparam int unsigned VstuCntWidth = $clog2(VstuMaxOutstanding + 1);

  localparam logic [1:0] AxiRespSlvErr = 2'b10;
  localparam logic [1:0] AxiRespDecErr = 2'b11;

  typedef logic [VInsnIdWidth-1:0] vinsn_id_t;
  typedef logic [VstuCntWidth-1:0] vstu_cnt_t;

  typedef struct packed {
    logic      valid;
    vinsn_id_t id;
    vstu_cnt_t burst_cnt;
    vstu_cnt_t b_cnt;
    logic      all_issued;
    logic      error;
  } vstu_commit_entry_t;

endpackage

`default_nettype wire

// File: rtl/vstu_commit_ctrl_if.sv
// ---------------------------------------------------------------------------
// vstu_commit_ctrl_if: accept / AW-issue / B / done signals of the commit ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface vstu_commit_ctrl_if;
  import vstu_commit_ctrl_pkg::*;

  logic      insn_valid;
  vinsn_id_t insn_id;
  logic      insn_empty;
  logic      insn_ready;
  logic      aw_issue_valid;
  logic      aw_issue_last;
  logic      aw_issue_ready;
  logic      axi_b_valid;
  logic [1:0] axi_b_resp;
  logic      axi_b_ready;
  logic      done_valid;
  vinsn_id_t done_id;
  logic      done_error;
  logic      store_pending;
  vstu_cnt_t outstanding;

  modport master (
    output insn_valid, insn_id, insn_empty, aw_issue_valid, aw_issue_last,
           axi_b_valid, axi_b_resp,
    input  insn_ready, aw_issue_ready, axi_b_ready, done_valid, done_id,
           done_error, store_pending, outstanding
  );

  modport slave (
    input  insn_valid, insn_id, insn_empty, aw_issue_valid, aw_issue_last,
           axi_b_valid, axi_b_resp,
    output insn_ready, aw_issue_ready, axi_b_ready, done_valid, done_id,
           done_error, store_pending, outstanding
  );

endinterface

`default_nettype wire

// File: rtl/vstu_commit_ctrl.sv
// ---------------------------------------------------------------------------
// vstu_commit_ctrl: matches issued AW bursts to B responses, retires stores in order. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vstu_commit_ctrl
  import vstu_commit_ctrl_pkg::*;
#(
  parameter int unsigned InsnQueueDepth = VstuInsnQueueDepth,
  parameter int unsigned MaxOutstanding = VstuMaxOutstanding
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  vstu_commit_ctrl_if.slave bus
);

  localparam int unsigned PtrWidth   = idx_width(InsnQueueDepth);
  localparam int unsigned CountWidth = $clog2(InsnQueueDepth + 1);

  typedef logic [PtrWidth-1:0]   ptr_t;
  typedef logic [CountWidth-1:0] count_t;

  localparam ptr_t      LastPtr     = ptr_t'(InsnQueueDepth - 1);
  localparam count_t    FullCount   = count_t'(InsnQueueDepth);
  localparam vstu_cnt_t CreditLimit = vstu_cnt_t'(MaxOutstanding);

  vstu_commit_entry_t queue_q [InsnQueueDepth];
  ptr_t               accept_ptr_q, burst_ptr_q, commit_ptr_q;
  count_t             count_q;
  vstu_cnt_t          outstanding_q;
  logic               done_valid_q;
  vinsn_id_t          done_id_q;
  logic               done_error_q;

  vstu_commit_entry_t burst_entry, commit_entry;
  logic full, insn_fire, aw_fire, b_fire, b_err, burst_skip, retire;

  function automatic ptr_t ptr_incr(input ptr_t ptr);
    return (ptr == LastPtr) ? '0 : ptr + ptr_t'(1);
  endfunction

  assign burst_entry  = queue_q[burst_ptr_q];
  assign commit_entry = queue_q[commit_ptr_q];

  assign full                = (count_q == FullCount);
  assign bus.insn_ready      = !full;
  assign bus.aw_issue_ready  = burst_entry.valid && !burst_entry.all_issued &&
                               (outstanding_q < CreditLimit);
  // B is only ever credited to the oldest store, so orphan responses are refused.
  assign bus.axi_b_ready     = commit_entry.valid && (commit_entry.b_cnt < commit_entry.burst_cnt);

  assign insn_fire  = bus.insn_valid && !full;
  assign aw_fire    = bus.aw_issue_valid && bus.aw_issue_ready;
  assign b_fire     = bus.axi_b_valid && bus.axi_b_ready;
  assign b_err      = (bus.axi_b_resp == AxiRespSlvErr) || (bus.axi_b_resp == AxiRespDecErr);
  assign burst_skip = burst_entry.valid && burst_entry.all_issued;
  assign retire     = commit_entry.valid && commit_entry.all_issued &&
                      (commit_entry.b_cnt == commit_entry.burst_cnt);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < InsnQueueDepth; i++) begin
        queue_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < InsnQueueDepth; i++) begin
        if (insn_fire && (accept_ptr_q == ptr_t'(i))) begin
          queue_q[i] <= '{valid: 1'b1, id: bus.insn_id, burst_cnt: '0, b_cnt: '0,
                          all_issued: bus.insn_empty, error: 1'b0};
        end else if (retire && (commit_ptr_q == ptr_t'(i))) begin
          queue_q[i] <= '0;
        end else begin
          if (aw_fire && (burst_ptr_q == ptr_t'(i))) begin
            queue_q[i].burst_cnt <= queue_q[i].burst_cnt + vstu_cnt_t'(1);
            if (bus.aw_issue_last) begin
              queue_q[i].all_issued <= 1'b1;
            end
          end
          if (b_fire && (commit_ptr_q == ptr_t'(i))) begin
            queue_q[i].b_cnt <= queue_q[i].b_cnt + vstu_cnt_t'(1);
            if (b_err) begin
              queue_q[i].error <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      accept_ptr_q  <= '0;
      burst_ptr_q   <= '0;
      commit_ptr_q  <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      done_valid_q  <= 1'b0;
      done_id_q     <= '0;
      done_error_q  <= 1'b0;
    end else begin
      if (insn_fire) begin
        accept_ptr_q <= ptr_incr(accept_ptr_q);
      end
      // Empty stores never see an AW; step past them as soon as they are reached.
      if ((aw_fire && bus.aw_issue_last) || burst_skip) begin
        burst_ptr_q <= ptr_incr(burst_ptr_q);
      end
      if (retire) begin
        commit_ptr_q <= ptr_incr(commit_ptr_q);
      end

      case ({insn_fire, retire})
        2'b10:   count_q <= count_q + count_t'(1);
        2'b01:   count_q <= count_q - count_t'(1);
        default: count_q <= count_q;
      endcase

      case ({aw_fire, b_fire})
        2'b10:   outstanding_q <= outstanding_q + vstu_cnt_t'(1);
        2'b01:   outstanding_q <= outstanding_q - vstu_cnt_t'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      done_valid_q <= retire;
      done_id_q    <= retire ? commit_entry.id : '0;
      done_error_q <= retire && commit_entry.error;
    end
  end

  assign bus.done_valid    = done_valid_q;
  assign bus.done_id       = done_id_q;
  assign bus.done_error    = done_error_q;
  assign bus.store_pending = (count_q != '0);
  assign bus.outstanding   = outstanding_q;

`ifndef SYNTHESIS
  a_no_b_without_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.axi_b_valid |-> (outstanding_q != '0));
  a_no_aw_on_empty_queue : assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.aw_issue_valid |-> (count_q != '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_vstu_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vstu_commit_ctrl: directed scenarios plus randomized traffic against a store-level model. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vstu_commit_ctrl;
  import vstu_commit_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vstu_commit_ctrl_if bus ();

  vstu_commit_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Reference model: one record per tracked store, oldest first.
  typedef struct {
    logic [2:0] id;
    int         issued;
    int         acked;
    bit         all_issued;
    bit         err;
  } st_t;

  st_t        mq[$];
  int         m_out;
  bit         e_done;
  logic [2:0] e_id;
  bit         e_err;
  int         n_cmp;
  int         n_fail;

  function automatic int m_first_unissued();
    foreach (mq[i]) if (!mq[i].all_issued) return i;
    return -1;
  endfunction

  function automatic bit m_aw_ready();
    return (m_first_unissued() >= 0) && (m_out < 16);
  endfunction

  function automatic bit m_b_ready();
    return (mq.size() > 0) && (mq[0].acked < mq[0].issued);
  endfunction

  function automatic bit m_insn_ready();
    return mq.size() < 4;
  endfunction

  task automatic clear_inputs();
    bus.insn_valid     = 1'b0;
    bus.insn_id        = '0;
    bus.insn_empty     = 1'b0;
    bus.aw_issue_valid = 1'b0;
    bus.aw_issue_last  = 1'b0;
    bus.axi_b_valid    = 1'b0;
    bus.axi_b_resp     = 2'b00;
  endtask

  task automatic model_clear();
    mq.delete();
    m_out  = 0;
    e_done = 1'b0;
    e_id   = 3'd0;
    e_err  = 1'b0;
  endtask

  // One clock: readiness decided from model state before the edge, model updated with the handshakes.
  task automatic tick();
    bit  ir, ar, br, ret;
    int  idx;
    st_t s;
    ir  = m_insn_ready();
    ar  = m_aw_ready();
    br  = m_b_ready();
    ret = (mq.size() > 0) && mq[0].all_issued && (mq[0].acked == mq[0].issued);
    @(posedge clk);
    if (bus.aw_issue_valid && ar) begin
      idx = m_first_unissued();
      s = mq[idx];
      s.issued++;
      if (bus.aw_issue_last) s.all_issued = 1'b1;
      mq[idx] = s;
      m_out++;
    end
    if (bus.axi_b_valid && br) begin
      s = mq[0];
      s.acked++;
      if (bus.axi_b_resp[1]) s.err = 1'b1;
      mq[0] = s;
      m_out--;
    end
    e_done = ret;
    e_id   = 3'd0;
    e_err  = 1'b0;
    if (ret) begin
      e_id  = mq[0].id;
      e_err = mq[0].err;
      void'(mq.pop_front());
    end
    if (bus.insn_valid && ir) begin
      s.id = bus.insn_id; s.issued = 0; s.acked = 0;
      s.all_issued = bus.insn_empty; s.err = 1'b0;
      mq.push_back(s);
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic accept(input logic [2:0] id, input bit empty);
    bus.insn_valid = 1'b1;
    bus.insn_id    = id;
    bus.insn_empty = empty;
    tick();
    bus.insn_valid = 1'b0;
    bus.insn_empty = 1'b0;
  endtask

  task automatic issue_aw(input bit last);
    bus.aw_issue_valid = 1'b1;
    bus.aw_issue_last  = last;
    tick();
    bus.aw_issue_valid = 1'b0;
    bus.aw_issue_last  = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] resp);
    bus.axi_b_valid = 1'b1;
    bus.axi_b_resp  = resp;
    tick();
    bus.axi_b_valid = 1'b0;
    bus.axi_b_resp  = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.insn_ready, bus.aw_issue_ready, bus.axi_b_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 100", {bus.insn_ready, bus.aw_issue_ready, bus.axi_b_ready});
    end
    n_cmp++;
    if ({bus.done_valid, bus.done_id, bus.done_error, bus.store_pending} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 000000",
               {bus.done_valid, bus.done_id, bus.done_error, bus.store_pending});
    end
    n_cmp++;
    if (bus.outstanding !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outstanding: got %0d want 0", bus.outstanding);
    end
  endtask

  task automatic test_single_store();
    do_reset();
    accept(3'd3, 1'b0);
    for (int k = 0; k < 4; k++) issue_aw(k == 3);
    n_cmp++;
    if ({bus.outstanding, bus.aw_issue_ready} !== {5'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL single_issued: got out=%0d awr=%b want out=4 awr=0", bus.outstanding, bus.aw_issue_ready);
    end
    for (int k = 0; k < 4; k++) send_b(2'b00);
    n_cmp++;
    if (bus.done_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early_done: got %b want 0", bus.done_valid);
    end
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.done_id, bus.done_error} !== {1'b1, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL single_done: got v=%b id=%0d err=%b want v=1 id=3 err=0",
               bus.done_valid, bus.done_id, bus.done_error);
    end
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.store_pending} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_after: got v=%b pend=%b want 0 0", bus.done_valid, bus.store_pending);
    end
  endtask

  task automatic test_credit_limit();
    do_reset();
    accept(3'd1, 1'b0);
    bus.aw_issue_valid = 1'b1;
    bus.aw_issue_last  = 1'b0;
    repeat (16) tick();
    n_cmp++;
    if ({bus.outstanding, bus.aw_issue_ready} !== {5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL credit_full: got out=%0d awr=%b want out=16 awr=0", bus.outstanding, bus.aw_issue_ready);
    end
    tick();
    n_cmp++;
    if (bus.outstanding !== 5'd16) begin
      n_fail++;
      $display("FAIL credit_hold: got %0d want 16", bus.outstanding);
    end
    bus.aw_issue_valid = 1'b0;
    send_b(2'b00);
    n_cmp++;
    if ({bus.outstanding, bus.aw_issue_ready} !== {5'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL credit_return: got out=%0d awr=%b want out=15 awr=1", bus.outstanding, bus.aw_issue_ready);
    end
  endtask

  task automatic test_full_queue();
    logic [2:0] ids [4] = '{3'd1, 3'd2, 3'd5, 3'd7};
    do_reset();
    foreach (ids[i]) accept(ids[i], 1'b0);
    n_cmp++;
    if ({bus.insn_ready, bus.store_pending} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_ready: got rdy=%b pend=%b want 0 1", bus.insn_ready, bus.store_pending);
    end
    issue_aw(1'b1);
    n_cmp++;
    if (bus.aw_issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_next_burst: got %b want 1", bus.aw_issue_ready);
    end
    // Keep offering a fifth store: it must not slip into the retiring slot.
    bus.insn_valid = 1'b1;
    bus.insn_id    = 3'd6;
    bus.axi_b_valid = 1'b1;
    tick();
    bus.axi_b_valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.done_id, bus.insn_ready} !== {1'b1, 3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL full_retire: got v=%b id=%0d rdy=%b want v=1 id=1 rdy=1",
               bus.done_valid, bus.done_id, bus.insn_ready);
    end
    tick();
    bus.insn_valid = 1'b0;
    n_cmp++;
    if (bus.insn_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refill: got %b want 0", bus.insn_ready);
    end
  endtask

  task automatic test_empty_store();
    do_reset();
    accept(3'd2, 1'b0);
    accept(3'd4, 1'b1);
    issue_aw(1'b0);
    issue_aw(1'b1);
    n_cmp++;
    if ({bus.outstanding, bus.aw_issue_ready} !== {5'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL empty_no_aw: got out=%0d awr=%b want out=2 awr=0", bus.outstanding, bus.aw_issue_ready);
    end
    send_b(2'b00);
    send_b(2'b00);
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.done_id} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL empty_first: got v=%b id=%0d want v=1 id=2", bus.done_valid, bus.done_id);
    end
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.done_id, bus.done_error} !== {1'b1, 3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL empty_second: got v=%b id=%0d err=%b want v=1 id=4 err=0",
               bus.done_valid, bus.done_id, bus.done_error);
    end
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.store_pending, bus.outstanding} !== {2'b00, 5'd0}) begin
      n_fail++;
      $display("FAIL empty_drained: got v=%b pend=%b out=%0d want 0 0 0",
               bus.done_valid, bus.store_pending, bus.outstanding);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] resps [4] = '{2'b00, 2'b10, 2'b00, 2'b00};
    logic [2:0] did [2];
    bit         derr [2];
    int         bi;
    int         nd;
    bit         fire;
    do_reset();
    accept(3'd5, 1'b0);
    accept(3'd6, 1'b0);
    for (int k = 0; k < 3; k++) issue_aw(k == 2);
    issue_aw(1'b1);
    bi = 0;
    nd = 0;
    did[0] = 3'd0; did[1] = 3'd0; derr[0] = 1'b0; derr[1] = 1'b0;
    for (int c = 0; c < 30 && nd < 2; c++) begin
      bus.axi_b_valid = (bi < 4);
      if (bi < 4) bus.axi_b_resp = resps[bi];
      fire = bus.axi_b_valid && m_b_ready();
      tick();
      if (fire) bi++;
      if (bus.done_valid === 1'b1) begin
        did[nd]  = bus.done_id;
        derr[nd] = bus.done_error;
        nd++;
      end
    end
    bus.axi_b_valid = 1'b0;
    n_cmp++;
    if (nd !== 2) begin
      n_fail++;
      $display("FAIL slverr_pulses: got %0d want 2", nd);
    end
    n_cmp++;
    if ({did[0], derr[0]} !== {3'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL slverr_first: got id=%0d err=%b want id=5 err=1", did[0], derr[0]);
    end
    n_cmp++;
    if ({did[1], derr[1]} !== {3'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL slverr_second: got id=%0d err=%b want id=6 err=0", did[1], derr[1]);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    accept(3'd1, 1'b0);
    accept(3'd2, 1'b0);
    for (int k = 0; k < 3; k++) issue_aw(k == 2);
    issue_aw(1'b0);
    issue_aw(1'b0);
    n_cmp++;
    if (bus.outstanding !== 5'd5) begin
      n_fail++;
      $display("FAIL midop_inflight: got %0d want 5", bus.outstanding);
    end
    bus.axi_b_valid = 1'b1;
    bus.insn_valid  = 1'b1;
    bus.insn_id     = 3'd7;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.insn_ready, bus.aw_issue_ready, bus.axi_b_ready, bus.done_valid, bus.done_id,
         bus.done_error, bus.store_pending, bus.outstanding} !== {3'b100, 1'b0, 3'd0, 2'b00, 5'd0}) begin
      n_fail++;
      $display("FAIL midop_reset_vals: rdy=%b awr=%b br=%b v=%b id=%0d err=%b pend=%b out=%0d",
               bus.insn_ready, bus.aw_issue_ready, bus.axi_b_ready, bus.done_valid, bus.done_id,
               bus.done_error, bus.store_pending, bus.outstanding);
    end
    clear_inputs();
    model_clear();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.done_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_no_done: cycle %0d got %b want 0", k, bus.done_valid);
      end
    end
    rst_n = 1'b1;
    accept(3'd6, 1'b1);
    tick();
    n_cmp++;
    if ({bus.done_valid, bus.done_id, bus.done_error} !== {1'b1, 3'd6, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_new_store: got v=%b id=%0d err=%b want v=1 id=6 err=0",
               bus.done_valid, bus.done_id, bus.done_error);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.insn_valid     = ($urandom_range(0, 2) == 0);
      bus.insn_id        = 3'($urandom);
      bus.insn_empty     = 1'b0;
      bus.aw_issue_valid = (m_first_unissued() >= 0) && ($urandom_range(0, 1) == 1);
      bus.aw_issue_last  = ($urandom_range(0, 2) == 0);
      // Slow B return in the first half drives the credit counter to its limit.
      bus.axi_b_valid    = (m_out > 0) && ($urandom_range(0, 3) < ((c < 300) ? 1 : 3));
      bus.axi_b_resp     = 2'($urandom);
      tick();
      n_cmp++;
      if ({bus.insn_ready, bus.aw_issue_ready, bus.axi_b_ready, bus.store_pending} !==
          {m_insn_ready(), m_aw_ready(), m_b_ready(), (mq.size() > 0)}) begin
        n_fail++;
        $display("FAIL rand_ready: cycle %0d got %b want %b", c,
                 {bus.insn_ready, bus.aw_issue_ready, bus.axi_b_ready, bus.store_pending},
                 {m_insn_ready(), m_aw_ready(), m_b_ready(), (mq.size() > 0)});
      end
      n_cmp++;
      if ({bus.done_valid, bus.done_id, bus.done_error} !== {e_done, e_id, e_err}) begin
        n_fail++;
        $display("FAIL rand_done: cycle %0d got v=%b id=%0d err=%b want v=%b id=%0d err=%b", c,
                 bus.done_valid, bus.done_id, bus.done_error, e_done, e_id, e_err);
      end
      n_cmp++;
      if (bus.outstanding !== 5'(m_out)) begin
        n_fail++;
        $display("FAIL rand_outstanding: cycle %0d got %0d want %0d", c, bus.outstanding, m_out);
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clear_inputs();
    model_clear();
    test_reset();
    test_single_store();
    test_credit_limit();
    test_full_queue();
    test_empty_store();
    test_slverr();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
